ps2_key_gen: RTL and testbench

PS2_KEY_GEN -- requirements
Module: ps2_key_gen

---
 rtl/ps2_key_gen.sv | 125 ++++++++++++
 tb/tb_ps2_key_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, deframes
// 11-bit frames and decodes E0/F0 prefixes into toggle-flagged key events.
module ps2_key_gen #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          filt_clk, filt_flip, fall;
  logic [FW-1:0] filt_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] tmo_cnt;
  logic          timeout, frame_done, frame_ok;
  logic [7:0]    rx_byte;
  logic          is_ext, is_brk;
  state_t        state, state_nxt;
  logic [10:0]   key_nxt;
  logic          err_nxt;

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end

  // filt_flip fires on the FILT_LEN-th consecutive sample that differs from filt_clk
  assign filt_flip = (clk_sync[1] != filt_clk) && (filt_cnt == FILT_MAX);
  assign fall      = filt_flip && filt_clk;

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      filt_clk <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end

  assign frame_done = fall && (bit_cnt == 4'd10);
  assign timeout    = !fall && (bit_cnt != 4'd0) && (tmo_cnt == TMO_MAX);

  // shreg collects start..parity; the stop bit is taken live from the synchronizer
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      tmo_cnt <= '0;
    end else if (fall) begin
      tmo_cnt <= '0;
      if (frame_done) bit_cnt <= '0;
      else begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {dat_sync[1], shreg[9:1]};
      end
    end else if (timeout) begin
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else if (bit_cnt != 4'd0) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end

  assign rx_byte  = shreg[8:1];
  assign frame_ok = !shreg[0] && (^shreg[9:1]) && dat_sync[1];
  assign is_ext   = (state == EXT) || (state == EXT_BRK);
  assign is_brk   = (state == BRK) || (state == EXT_BRK);

  always_comb begin
    state_nxt = state;
    key_nxt   = ps2_key;
    err_nxt   = 1'b0;
    if (timeout) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
    end else if (frame_done) begin
      if (!frame_ok) begin
        state_nxt = IDLE;
        err_nxt   = 1'b1;
      end else begin
        case (rx_byte)
          8'hE0: state_nxt = is_brk ? EXT_BRK : EXT;
          8'hF0: state_nxt = is_ext ? EXT_BRK : BRK;
          8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_nxt = IDLE;
          default: begin
            key_nxt   = {~ps2_key[10], ~is_brk, is_ext, rx_byte};
            state_nxt = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state     <= IDLE;
      ps2_key   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      ps2_key   <= key_nxt;
      frame_err <= err_nxt;
    end

endmodule

// File: tb/tb_ps2_key_gen.sv
// Randomized bench for ps2_key_gen: frames are driven on the raw PS/2 lines and
// checked against a prefix-flag model of the keyboard protocol.
module tb_ps2_key_gen;
  localparam int FILT = 8;
  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int errors = 0, checks = 0;
  int err_cycles = 0, exp_err = 0;
  logic [10:0] exp_key = '0;
  bit m_ext = 0, m_brk = 0;

  always #5 clk_sys = ~clk_sys;

  ps2_key_gen #(.FILT_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_key(ps2_key), .frame_err(frame_err)
  );

  // high cycles of frame_err; one per rejected frame or timeout
  always @(negedge clk_sys) if (!reset && frame_err) err_cycles++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (kind == 1) f[9]  = ~f[9];
    if (kind == 2) f[10] = 1'b0;
    if (kind == 3) f[0]  = 1'b1;
    return f;
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      idle(HALF);
      ps2_clk = 1'b0;
      idle(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic model(input logic [7:0] b, input int kind);
    if (kind != 0) begin
      exp_err++;
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      exp_key = {~exp_key[10], ~m_brk, m_ext, b};
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input int kind);
    send_bits(mk_frame(b, kind), 11);
    model(b, kind);
    idle(30);
    chk({tag, "_key"}, 32'(ps2_key), 32'(exp_key));
    chk({tag, "_err"}, err_cycles, exp_err);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] disc [7] = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    int kind;

    idle(4);
    chk("rst_key", 32'(ps2_key), 32'h000);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_cnt", 32'(dut.bit_cnt), 32'h0);
    reset = 1'b0;
    idle(10);

    frame("f29", 8'h29, 0);
    chk("f29_lit", 32'(ps2_key), 32'h629);
    frame("e0", 8'hE0, 0);
    frame("f0", 8'hF0, 0);
    frame("f75", 8'h75, 0);
    chk("f75_lit", 32'(ps2_key), 32'h175);
    frame("bad1c", 8'h1C, 1);
    frame("f1c", 8'h1C, 0);
    chk("f1c_lit", 32'(ps2_key), 32'h61C);

    ps2_clk = 1'b0;
    idle(3);
    ps2_clk = 1'b1;
    idle(20);
    chk("glitch_cnt", 32'(dut.bit_cnt), 32'h0);
    frame("post_glitch", 8'h3A, 0);

    send_bits(mk_frame(8'h16, 0), 5);
    chk("part_cnt", 32'(dut.bit_cnt), 32'd5);
    idle(TMO + 1);
    exp_err++;
    m_ext = 0; m_brk = 0;
    chk("tmo_err", err_cycles, exp_err);
    chk("tmo_cnt", 32'(dut.bit_cnt), 32'h0);
    frame("f16", 8'h16, 0);
    chk("f16_press", 32'(ps2_key[9:0]), 32'h216);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1, 2: b = 8'hF0;
        3: b = disc[$urandom_range(0, 6)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      kind = ($urandom_range(0, 7) < 6) ? 0 : int'($urandom_range(1, 3));
      frame("rnd", b, kind);
    end

    frame("pre_f0", 8'hF0, 0);
    send_bits(mk_frame(8'h14, 0), 5);
    reset = 1'b1;
    idle(3);
    chk("mid_rst_key", 32'(ps2_key), 32'h000);
    chk("mid_rst_cnt", 32'(dut.bit_cnt), 32'h0);
    exp_key = '0;
    m_ext = 0; m_brk = 0;
    reset = 1'b0;
    idle(10);
    frame("f14", 8'h14, 0);
    chk("f14_lit", 32'(ps2_key), 32'h614);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
